// File: rtl/types_pkg.sv
// Shared types for the CPU data path and its memory-side responder.
// Holds the common data bus, byte-enable and responder FSM state types.
package types_pkg;
    typedef logic [31:0] DATA_BUS;
    typedef logic [3:0]  BYTE_EN;

    typedef enum logic [1:0] {MR_IDLE, MR_WAIT, MR_RESP} mem_rsp_state;

    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/dmem_array.sv
// Purpose: DEPTH_WORDS x 32 data RAM, byte-enabled write, combinational read.
// Latency: write commits on the clock edge; read is combinational.
// Backpressure: none, always accepts the write strobe.
module dmem_array
    import types_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  BYTE_EN                         be,
    input  DATA_BUS                        wdata,
    output DATA_BUS                        rdata
);
    DATA_BUS mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// Purpose: valid/ready data-memory slave with wait states and range/alignment errors.
// Latency: response valid LATENCY+1 cycles after the accept cycle.
// Backpressure: holds the response until rsp_ready; no new accept until then.
module data_mem_responder
    import types_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    req_valid,
    output logic    req_ready,
    input  DATA_BUS req_addr,
    input  logic    req_we,
    input  BYTE_EN  req_be,
    input  DATA_BUS req_wdata,
    output logic    rsp_valid,
    input  logic    rsp_ready,
    output DATA_BUS rsp_rdata,
    output logic    rsp_err
);
    localparam int          AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    mem_rsp_state state_q, state_d;
    logic [3:0]   cnt_q;
    DATA_BUS      addr_q, wdata_q, rdata_q;
    BYTE_EN       be_q;
    logic         we_q, err_q;

    logic         accept, enter_resp;
    DATA_BUS      acc_addr, acc_off, acc_wdata, ram_rdata;
    BYTE_EN       acc_be;
    logic         acc_we, acc_err;

    assign req_ready = (state_q == MR_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // While idle the live request feeds the access so a zero-latency build
    // can execute it on the accept edge itself.
    assign acc_addr  = (state_q == MR_IDLE) ? req_addr  : addr_q;
    assign acc_we    = (state_q == MR_IDLE) ? req_we    : we_q;
    assign acc_be    = (state_q == MR_IDLE) ? req_be    : be_q;
    assign acc_wdata = (state_q == MR_IDLE) ? req_wdata : wdata_q;

    assign acc_off = acc_addr - BASE_ADDR;
    assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_off >> 2) >= DATA_BUS'(DEPTH_WORDS));

    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        case (state_q)
            MR_IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d    = MR_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d    = MR_WAIT;
                    end
                end
            end
            MR_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d    = MR_RESP;
                    enter_resp = 1'b1;
                end
            end
            MR_RESP: begin
                if (rsp_ready) state_d = MR_IDLE;
            end
            default: state_d = MR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MR_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q   <= LAT;
                addr_q  <= req_addr;
                we_q    <= req_we;
                be_q    <= req_be;
                wdata_q <= req_wdata;
            end else if (state_q == MR_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (acc_we || acc_err) ? '0 : ram_rdata;
            end
        end
    end

    // The RAM has no reset, so the write strobe is gated to keep an
    // aborting reset from committing a pending write.
    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .wr_en (enter_resp && acc_we && !acc_err && !rst),
        .addr  (acc_off[AW+1:2]),
        .be    (acc_be),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    assign rsp_valid = (state_q == MR_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 instance driven from a vector
// table plus hand sequences, and a LATENCY=0 instance run back-to-back.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    localparam int LAT_A = 2;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [3:0]  z_req_be;

    data_mem_responder #(.BASE_ADDR(32'h0001_0000), .DEPTH_WORDS(4096), .LATENCY(LAT_A)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.BASE_ADDR(32'h0001_0000), .DEPTH_WORDS(4096), .LATENCY(0)) dut_z (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
        .req_we(z_req_we), .req_be(z_req_be), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(1'b1),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_z[$];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Scoreboard monitors: check response timing on the rising edge of
    // rsp_valid and data/error on the handshake cycle.
    logic pv_a = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rsp_valid && !pv_a) begin
                if (q_a.size() == 0) fail_now("a_unexpected_rsp");
                else                 cmp("a_latency", cyc, q_a[0].due);
            end
            if (rsp_valid && rsp_ready && q_a.size() > 0) begin
                e = q_a.pop_front();
                cmp("a_rdata", rsp_rdata, e.rdata);
                cmp("a_err", 32'(rsp_err), 32'(e.err));
            end
        end
        pv_a = rsp_valid;
    end

    logic pv_z = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (z_rsp_valid && !pv_z) begin
                if (q_z.size() == 0) fail_now("z_unexpected_rsp");
                else                 cmp("z_latency", cyc, q_z[0].due);
            end
            if (z_rsp_valid && q_z.size() > 0) begin
                e = q_z.pop_front();
                cmp("z_rdata", z_rsp_rdata, e.rdata);
                cmp("z_err", 32'(z_rsp_err), 32'(e.err));
            end
        end
        pv_z = z_rsp_valid;
    end

    task automatic issue_a(input vec_t v, input bit push);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_we    = v.we;
        req_be    = v.be;
        req_wdata = v.wdata;
        while (n < 50) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) fail_now("a_accept_timeout");
        else if (push) q_a.push_back('{v.exp_rdata, v.exp_err, cyc + 1 + LAT_A});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_a();
        int n;
        n = 0;
        while (q_a.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q_a.size() != 0) begin
            fail_now("a_response_timeout");
            q_a.delete();
        end
    endtask

    vec_t tab_a[18];
    vec_t tab_z[7];

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, last_t;
        vec_t v;

        tab_a[0]  = '{32'h0001_0000, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
        tab_a[1]  = '{32'h0001_0000, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
        tab_a[2]  = '{32'h0001_0004, 1'b1, 4'hF, 32'h11223344, 32'h0, 1'b0};
        tab_a[3]  = '{32'h0001_0004, 1'b1, 4'h5, 32'hAABBCCDD, 32'h0, 1'b0};
        tab_a[4]  = '{32'h0001_0004, 1'b0, 4'hF, 32'h0,        32'h11BB33DD, 1'b0};
        tab_a[5]  = '{32'h0001_0004, 1'b0, 4'h0, 32'h0,        32'h11BB33DD, 1'b0};
        tab_a[6]  = '{32'h0001_0002, 1'b0, 4'hF, 32'h0,        32'h0, 1'b1};
        tab_a[7]  = '{32'h0001_3FFC, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0};
        tab_a[8]  = '{32'h0000_FFFC, 1'b1, 4'hF, 32'h1,        32'h0, 1'b1};
        tab_a[9]  = '{32'h0001_4000, 1'b1, 4'hF, 32'h1,        32'h0, 1'b1};
        tab_a[10] = '{32'h0001_0001, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1};
        tab_a[11] = '{32'h0001_0000, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
        tab_a[12] = '{32'h0001_3FFC, 1'b0, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0};
        tab_a[13] = '{32'h0001_0008, 1'b1, 4'hF, 32'h55AA55AA, 32'h0, 1'b0};
        tab_a[14] = '{32'h0001_0008, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0};
        tab_a[15] = '{32'h0001_0008, 1'b0, 4'hF, 32'h0,        32'h55AA55AA, 1'b0};
        tab_a[16] = '{32'h0000_0000, 1'b0, 4'hF, 32'h0,        32'h0, 1'b1};
        tab_a[17] = '{32'h0001_4000, 1'b0, 4'hF, 32'h0,        32'h0, 1'b1};

        tab_z[0] = '{32'h0001_0100, 1'b1, 4'hF, 32'hA5A50001, 32'h0, 1'b0};
        tab_z[1] = '{32'h0001_0100, 1'b0, 4'hF, 32'h0,        32'hA5A50001, 1'b0};
        tab_z[2] = '{32'h0001_0104, 1'b1, 4'hF, 32'h0F0F0F0F, 32'h0, 1'b0};
        tab_z[3] = '{32'h0001_0104, 1'b0, 4'hF, 32'h0,        32'h0F0F0F0F, 1'b0};
        tab_z[4] = '{32'h0001_0103, 1'b0, 4'hF, 32'h0,        32'h0, 1'b1};
        tab_z[5] = '{32'h0000_0000, 1'b1, 4'hF, 32'h7,        32'h0, 1'b1};
        tab_z[6] = '{32'h0001_0100, 1'b0, 4'hF, 32'h0,        32'hA5A50001, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_be = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_addr = '0; z_req_we = 1'b0; z_req_be = '0; z_req_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        cmp("rst_req_ready", 32'(req_ready), 0);
        cmp("rst_rsp_valid", 32'(rsp_valid), 0);
        cmp("rst_rsp_rdata", rsp_rdata, 0);
        cmp("rst_rsp_err", 32'(rsp_err), 0);
        cmp("rst_z_req_ready", 32'(z_req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        cmp("post_rst_req_ready", 32'(req_ready), 1);

        for (int i = 0; i < 18; i++) begin
            issue_a(tab_a[i], 1'b1);
            wait_a();
        end

        // Backpressure: response held while rsp_ready is low
        rsp_ready = 1'b0;
        issue_a('{32'h0001_0000, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0}, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        if (!rsp_valid) fail_now("bp_no_rsp");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req_valid = (i == 1 || i == 2);
            req_addr  = 32'h0001_0004;
            req_we    = 1'b0;
            @(negedge clk);
            cmp("bp_valid", 32'(rsp_valid), 1);
            cmp("bp_rdata", rsp_rdata, 32'hDEADBEEF);
            cmp("bp_err", 32'(rsp_err), 0);
            cmp("bp_req_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmp("bp_hs_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        cmp("bp_valid_drop", 32'(rsp_valid), 0);
        cmp("bp_ready_back", 32'(req_ready), 1);
        repeat (5) @(negedge clk);
        cmp("bp_queue_empty", q_a.size(), 0);

        // Reset asserted while a write is waiting
        issue_a('{32'h0001_0008, 1'b1, 4'hF, 32'h12345678, 32'h0, 1'b0}, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmp("mid_rst_rsp_valid", 32'(rsp_valid), 0);
            cmp("mid_rst_req_ready", 32'(req_ready), 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        issue_a('{32'h0001_0008, 1'b0, 4'hF, 32'h0, 32'h55AA55AA, 1'b0}, 1'b1);
        wait_a();

        // Zero-latency instance: request held valid, accepts every 2 cycles
        @(posedge clk); #1;
        v = tab_z[0];
        z_req_valid = 1'b1;
        z_req_addr = v.addr; z_req_we = v.we; z_req_be = v.be; z_req_wdata = v.wdata;
        k = 0;
        n = 0;
        last_t = 0;
        while (k < 7 && n < 100) begin
            @(negedge clk);
            n++;
            if (z_req_ready) begin
                q_z.push_back('{tab_z[k].exp_rdata, tab_z[k].exp_err, cyc + 1});
                if (k > 0) cmp("z_accept_gap", cyc - last_t, 2);
                last_t = cyc;
                k++;
                @(posedge clk); #1;
                if (k < 7) begin
                    v = tab_z[k];
                    z_req_addr = v.addr; z_req_we = v.we; z_req_be = v.be; z_req_wdata = v.wdata;
                end else begin
                    z_req_valid = 1'b0;
                end
            end
        end
        if (k < 7) fail_now("z_accept_timeout");
        z_req_valid = 1'b0;
        n = 0;
        while (q_z.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q_z.size() != 0) fail_now("z_response_timeout");
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
